// File: rtl/step_sched_pkg.sv
// rtl/step_sched_pkg.sv - shared types and helpers for the step share scheduler
package step_sched_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  // Width of an index into n requesters; never narrower than one bit.
  function automatic int idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/step_share_sched_rr_arbiter.sv
// rtl/step_share_sched_rr_arbiter.sv - combinational round-robin pick starting at ptr
module rr_arbiter
  import step_sched_pkg::*;
#(
  parameter int NREQ = 4,
  parameter int IW   = idx_w(NREQ)
) (
  input  logic [NREQ-1:0] req,
  input  logic [IW-1:0]   ptr,
  input  logic            en,
  output logic [NREQ-1:0] grant,
  output logic [IW-1:0]   idx
);

  logic found;
  int   k;

  // Scan ptr, ptr+1, ... wrapping, and take the first requester that is asking.
  always_comb begin
    grant = '0;
    idx   = '0;
    found = 1'b0;
    k     = 0;
    for (int off = 0; off < NREQ; off++) begin
      k = (int'(ptr) + off) % NREQ;
      if (en && !found && req[k]) begin
        grant[k] = 1'b1;
        idx      = IW'(k);
        found    = 1'b1;
      end
    end
  end

endmodule

// File: rtl/step_share_sched.sv
// rtl/step_share_sched.sv - round-robin sharing of one bounded (i, sn) step counter pair
module step_share_sched
  import step_sched_pkg::*;
#(
  parameter int NREQ  = 4,
  parameter int WIDTH = 16,
  parameter int LIMIT = 70
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   start,
  input  logic                   abort,
  input  logic [NREQ-1:0]        req,
  output logic [NREQ-1:0]        grant,
  output logic [idx_w(NREQ)-1:0] owner,
  output logic [WIDTH-1:0]       i,
  output logic [WIDTH-1:0]       sn,
  output logic                   busy,
  output logic                   done
);

  localparam int IW = idx_w(NREQ);
  localparam logic [WIDTH-1:0] LIM = WIDTH'(LIMIT);

  state_t        state;
  logic [IW-1:0] ptr;
  logic [IW-1:0] gidx;
  logic          arb_en;

  // Steps are only offered while running, inside the bound, and not being aborted.
  assign arb_en = (state == RUN) && !abort && (i <= LIM);

  rr_arbiter #(
    .NREQ(NREQ),
    .IW  (IW)
  ) u_arb (
    .req  (req),
    .ptr  (ptr),
    .en   (arb_en),
    .grant(grant),
    .idx  (gidx)
  );

  assign busy = (state == RUN);
  assign done = (state == DONE);

  // Run/done sequencing plus counter, pointer and owner updates on each granted step.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= IDLE;
      i     <= WIDTH'(1);
      sn    <= '0;
      ptr   <= '0;
      owner <= '0;
    end else if (abort) begin
      state <= IDLE;
    end else begin
      case (state)
        IDLE, DONE: begin
          if (start) begin
            state <= RUN;
            i     <= WIDTH'(1);
            sn    <= '0;
            ptr   <= '0;
          end
        end
        RUN: begin
          if (i > LIM) begin
            state <= DONE;
          end else if (|grant) begin
            i     <= i + 1'b1;
            sn    <= sn + 1'b1;
            owner <= gidx;
            ptr   <= (gidx == IW'(NREQ - 1)) ? '0 : gidx + 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_step_share_sched.sv
// tb/tb_step_share_sched.sv - randomized self-checking bench for step_share_sched
module tb_step_share_sched;

  localparam int NREQ  = 4;
  localparam int WIDTH = 16;
  localparam int LIMIT = 70;
  localparam int M_IDLE = 0;
  localparam int M_RUN  = 1;
  localparam int M_DONE = 2;

  logic             clk = 1'b0;
  logic             rst;
  logic             start;
  logic             abort;
  logic [NREQ-1:0]  req;
  logic [NREQ-1:0]  grant;
  logic [1:0]       owner;
  logic [WIDTH-1:0] i;
  logic [WIDTH-1:0] sn;
  logic             busy;
  logic             done;

  int n_cmp = 0;
  int n_bad = 0;

  // reference model: abstract run state and plain integer counters
  int rm_state;
  int rm_i;
  int rm_sn;
  int rm_ptr;
  int rm_owner;
  int wait_cnt [NREQ];

  logic [NREQ-1:0] last_grant;
  logic [NREQ-1:0] last_eg;

  step_share_sched #(
    .NREQ (NREQ),
    .WIDTH(WIDTH),
    .LIMIT(LIMIT)
  ) dut (
    .clk  (clk),
    .rst  (rst),
    .start(start),
    .abort(abort),
    .req  (req),
    .grant(grant),
    .owner(owner),
    .i    (i),
    .sn   (sn),
    .busy (busy),
    .done (done)
  );

  always #5 clk = ~clk;

  task automatic model_reset();
    rm_state = M_IDLE;
    rm_i     = 1;
    rm_sn    = 0;
    rm_ptr   = 0;
    rm_owner = 0;
    for (int k = 0; k < NREQ; k++) wait_cnt[k] = 0;
  endtask

  function automatic logic [NREQ-1:0] model_grant(input logic [NREQ-1:0] r, input logic a);
    logic [NREQ-1:0] one;
    int k;
    one = 1;
    if (rm_state != M_RUN || a || rm_i > LIMIT) return '0;
    for (int off = 0; off < NREQ; off++) begin
      k = (rm_ptr + off) % NREQ;
      if (r[k]) return one << k;
    end
    return '0;
  endfunction

  task automatic model_step(input logic [NREQ-1:0] eg, input logic s, input logic a);
    if (a) begin
      rm_state = M_IDLE;
    end else if (rm_state == M_RUN) begin
      if (rm_i > LIMIT) begin
        rm_state = M_DONE;
      end else if (eg != 0) begin
        for (int k = 0; k < NREQ; k++) if (eg[k]) rm_owner = k;
        rm_i   = rm_i + 1;
        rm_sn  = rm_sn + 1;
        rm_ptr = (rm_owner + 1) % NREQ;
      end
    end else if (s) begin
      rm_state = M_RUN;
      rm_i     = 1;
      rm_sn    = 0;
      rm_ptr   = 0;
    end
  endtask

  task automatic cycle(input logic [NREQ-1:0] r, input logic s, input logic a);
    logic [NREQ-1:0] eg;
    @(negedge clk);
    req = r; start = s; abort = a;
    #1;
    eg = model_grant(r, a);
    n_cmp++;
    if (grant !== eg) begin
      n_bad++;
      $display("FAIL grant: got %b want %b at i=%0d", grant, eg, rm_i);
    end
    n_cmp++;
    if ((grant & (grant - 1'b1)) != 0) begin
      n_bad++;
      $display("FAIL grant_onehot: got %b want zero or one-hot", grant);
    end
    for (int k = 0; k < NREQ; k++) begin
      if (rm_state != M_RUN || !r[k] || grant[k]) wait_cnt[k] = 0;
      else if (grant != 0) begin
        wait_cnt[k]++;
        n_cmp++;
        if (wait_cnt[k] > NREQ - 1) begin
          n_bad++;
          $display("FAIL fairness: req %0d passed over %0d times want <= %0d", k, wait_cnt[k], NREQ - 1);
        end
      end
    end
    last_grant = grant;
    last_eg    = eg;
    @(posedge clk);
    #1;
    model_step(eg, s, a);
    n_cmp++;
    if (i !== WIDTH'(rm_i) || sn !== WIDTH'(rm_sn)) begin
      n_bad++;
      $display("FAIL counters: got i=%0d sn=%0d want i=%0d sn=%0d", i, sn, rm_i, rm_sn);
    end
    n_cmp++;
    if (owner !== 2'(rm_owner) || busy !== (rm_state == M_RUN) || done !== (rm_state == M_DONE)) begin
      n_bad++;
      $display("FAIL status: got owner=%0d busy=%b done=%b want owner=%0d state=%0d",
               owner, busy, done, rm_owner, rm_state);
    end
    n_cmp++;
    if (sn !== i - 1'b1) begin
      n_bad++;
      $display("FAIL sn_eq_i_minus_1: got i=%0d sn=%0d", i, sn);
    end
  endtask

  task automatic test_reset();
    rst = 1'b0; start = 1'b0; abort = 1'b0; req = 4'hF;
    model_reset();
    repeat (3) @(negedge clk);
    #1;
    n_cmp++;
    if (i !== 16'd1 || sn !== 16'd0 || owner !== 2'd0 || busy !== 1'b0 || done !== 1'b0 || grant !== 4'b0) begin
      n_bad++;
      $display("FAIL reset_state: got i=%0d sn=%0d owner=%0d busy=%b done=%b grant=%b want 1 0 0 0 0 0000",
               i, sn, owner, busy, done, grant);
    end
    @(negedge clk);
    rst = 1'b1; req = '0;
    cycle(4'hF, 1'b0, 1'b0);
    n_cmp++;
    if (last_grant !== 4'b0 || busy !== 1'b0) begin
      n_bad++;
      $display("FAIL idle_no_grant: got grant=%b busy=%b want 0000 0", last_grant, busy);
    end
  endtask

  task automatic test_single_req();
    int cnt;
    cnt = 0;
    cycle(4'b0001, 1'b1, 1'b0);
    for (int n = 0; n < 100 && !done; n++) begin
      cycle(4'b0001, 1'b0, 1'b0);
      if (last_grant == 4'b0001) cnt++;
    end
    n_cmp++;
    if (cnt != 70 || i !== 16'd71 || sn !== 16'd70 || done !== 1'b1 || owner !== 2'd0) begin
      n_bad++;
      $display("FAIL single_req: got grants=%0d i=%0d sn=%0d done=%b owner=%0d want 70 71 70 1 0",
               cnt, i, sn, done, owner);
    end
    cycle(4'b0001, 1'b0, 1'b0);
    n_cmp++;
    if (last_grant !== 4'b0) begin
      n_bad++;
      $display("FAIL single_after_done: got grant=%b want 0000", last_grant);
    end
  endtask

  task automatic test_all_req();
    int n;
    logic [NREQ-1:0] one;
    one = 1;
    n = 0;
    cycle(4'hF, 1'b1, 1'b0);
    for (int c = 0; c < 100 && !done; c++) begin
      cycle(4'hF, 1'b0, 1'b0);
      if (last_eg != 0) begin
        n_cmp++;
        if (last_grant !== (one << (n % 4)) || owner !== 2'(n % 4)) begin
          n_bad++;
          $display("FAIL rr_sequence: step %0d got grant=%b owner=%0d want %b %0d",
                   n, last_grant, owner, one << (n % 4), n % 4);
        end
        n++;
      end
    end
    n_cmp++;
    if (n != 70 || sn !== 16'd70 || done !== 1'b1) begin
      n_bad++;
      $display("FAIL all_req_total: got grants=%0d sn=%0d done=%b want 70 70 1", n, sn, done);
    end
  endtask

  task automatic test_gap();
    int par;
    logic [WIDTH-1:0] i0, sn0;
    par = 0;
    cycle(4'b1010, 1'b1, 1'b0);
    for (int c = 0; c < 20; c++) begin
      cycle(4'b1010, 1'b0, 1'b0);
      n_cmp++;
      if (last_grant !== ((par % 2 == 0) ? 4'b0010 : 4'b1000)) begin
        n_bad++;
        $display("FAIL gap_alternate: step %0d got %b", par, last_grant);
      end
      par++;
    end
    i0 = i; sn0 = sn;
    for (int c = 0; c < 5; c++) begin
      cycle(4'b0000, 1'b0, 1'b0);
      n_cmp++;
      if (i !== i0 || sn !== sn0 || last_grant !== 4'b0) begin
        n_bad++;
        $display("FAIL gap_freeze: got i=%0d sn=%0d grant=%b want i=%0d sn=%0d 0000", i, sn, last_grant, i0, sn0);
      end
    end
    for (int c = 0; c < 100 && !done; c++) begin
      cycle(4'b1010, 1'b0, 1'b0);
      if (last_eg != 0) begin
        n_cmp++;
        if (last_grant !== ((par % 2 == 0) ? 4'b0010 : 4'b1000)) begin
          n_bad++;
          $display("FAIL gap_alternate: step %0d got %b", par, last_grant);
        end
        par++;
      end
    end
    n_cmp++;
    if (par != 70 || sn !== 16'd70) begin
      n_bad++;
      $display("FAIL gap_total: got grants=%0d sn=%0d want 70 70", par, sn);
    end
  endtask

  task automatic test_abort();
    cycle(4'($urandom_range(1, 15)), 1'b1, 1'b0);
    for (int c = 0; c < 200 && sn != 16'd25; c++) cycle(4'($urandom_range(1, 15)), 1'b0, 1'b0);
    cycle(4'hF, 1'b1, 1'b1);
    n_cmp++;
    if (last_grant !== 4'b0 || busy !== 1'b0 || done !== 1'b0 || i !== 16'd26 || sn !== 16'd25) begin
      n_bad++;
      $display("FAIL abort: got grant=%b busy=%b done=%b i=%0d sn=%0d want 0000 0 0 26 25",
               last_grant, busy, done, i, sn);
    end
    cycle(4'hF, 1'b0, 1'b0);
    cycle(4'h0, 1'b1, 1'b0);
    n_cmp++;
    if (busy !== 1'b1 || i !== 16'd1 || sn !== 16'd0) begin
      n_bad++;
      $display("FAIL restart_after_abort: got busy=%b i=%0d sn=%0d want 1 1 0", busy, i, sn);
    end
  endtask

  task automatic test_async_reset();
    for (int c = 0; c < 400 && sn != 16'd40; c++) cycle(4'($urandom), 1'b0, 1'b0);
    @(posedge clk);
    #3;
    rst = 1'b0;
    #1;
    n_cmp++;
    if (i !== 16'd1 || sn !== 16'd0 || busy !== 1'b0 || done !== 1'b0 || grant !== 4'b0) begin
      n_bad++;
      $display("FAIL async_reset: got i=%0d sn=%0d busy=%b done=%b grant=%b want 1 0 0 0 0000",
               i, sn, busy, done, grant);
    end
    model_reset();
    @(negedge clk);
    rst = 1'b1; req = '0; start = 1'b0; abort = 1'b0;
  endtask

  task automatic test_done_hold();
    cycle(4'($urandom_range(1, 15)), 1'b1, 1'b0);
    for (int c = 0; c < 600 && !done; c++) cycle(4'($urandom), 1'b0, 1'b0);
    for (int c = 0; c < 10; c++) begin
      cycle(4'hF, 1'b0, 1'b0);
      n_cmp++;
      if (last_grant !== 4'b0 || i !== 16'd71 || sn !== 16'd70 || done !== 1'b1) begin
        n_bad++;
        $display("FAIL done_hold: got grant=%b i=%0d sn=%0d done=%b want 0000 71 70 1", last_grant, i, sn, done);
      end
    end
    cycle(4'hF, 1'b1, 1'b0);
    cycle(4'hF, 1'b0, 1'b0);
    n_cmp++;
    if (last_grant !== 4'b0001 || busy !== 1'b1 || i !== 16'd2) begin
      n_bad++;
      $display("FAIL done_restart: got grant=%b busy=%b i=%0d want 0001 1 2", last_grant, busy, i);
    end
  endtask

  task automatic test_random();
    for (int c = 0; c < 3000; c++) begin
      cycle(4'($urandom), ($urandom_range(0, 9) == 0), ($urandom_range(0, 63) == 0));
    end
  endtask

  initial begin
    test_reset();
    test_single_req();
    test_all_req();
    test_gap();
    test_abort();
    test_async_reset();
    test_done_hold();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
